// File: rtl/data_mem_resp_pkg.sv
// rtl/data_mem_resp_pkg.sv - shared command encoding, FSM states and default width for the memory responder
package data_mem_resp_pkg;

   localparam int MC_MW      = 0;
   localparam int MC_MR      = 1;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_ST = 2'd1,
      ACCESS  = 2'd2
   } state_t;

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - single-port DEPTH x DATA_W storage, synchronous write, registered read
module data_mem_array #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 200
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents deliberately survive reset; the caller only asserts we for in-range addresses.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - memory responder: request latch, wait-state FSM, ready/busy/err flags
module data_mem_resp
   import data_mem_resp_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 200,
   parameter int WAIT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        MC,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] WRdata,
   output logic [DATA_W-1:0] Mdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   localparam logic [2:0] WAIT_LAST = 3'((WAIT == 0) ? 0 : WAIT - 1);

   state_t            state;
   logic [2:0]        wait_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              write_q;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              in_range;
   logic              mem_we;

   // The array sees the live address while idle so its registered read is ready even when WAIT is 0.
   assign mem_addr = (state == IDLE) ? addr : addr_q;
   assign in_range = 32'(addr_q) < DEPTH;
   assign mem_we   = (state == ACCESS) && write_q && in_range && !rst;

   data_mem_array #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
   ) u_array (
      .clk  (clk),
      .we   (mem_we),
      .addr (mem_addr),
      .wdata(wdata_q),
      .rdata(rdata)
   );

   always_ff @(posedge clk) begin
      ready <= 1'b0;
      err   <= 1'b0;
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         busy     <= 1'b0;
         Mdata    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (MC != 2'b00) begin
                  addr_q   <= addr;
                  wdata_q  <= WRdata;
                  write_q  <= MC[MC_MW];
                  err      <= MC[MC_MW] & MC[MC_MR];
                  busy     <= 1'b1;
                  wait_cnt <= '0;
                  state    <= (WAIT == 0) ? ACCESS : WAIT_ST;
               end
            end
            WAIT_ST: begin
               if (wait_cnt == WAIT_LAST) begin
                  wait_cnt <= '0;
                  state    <= ACCESS;
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            ACCESS: begin
               if (!write_q) begin
                  Mdata <= in_range ? rdata : '0;
               end
               ready <= 1'b1;
               err   <= !in_range;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - scoreboard bench for data_mem_resp across WAIT = 0, 1, 3
module tb_data_mem_resp;
   import data_mem_resp_pkg::*;

   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 200;
   localparam int NDUT  = 3;

   typedef struct {
      int             dut;
      int             due;
      bit             is_rdy;
      bit             err_exp;
      logic [DW-1:0]  md;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      mc     [NDUT];
   logic [AW-1:0]   addr   [NDUT];
   logic [DW-1:0]   wrdata [NDUT];
   logic [DW-1:0]   mdata  [NDUT];
   logic [NDUT-1:0] ready, busy, err;

   int              cyc = 0;
   int              n_pass = 0;
   int              n_total = 0;
   exp_t            sb[$];
   logic [DW-1:0]   mem_model [NDUT][256];
   logic [DW-1:0]   md_model  [NDUT];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      data_mem_resp #(
         .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT((g == 2) ? 3 : g)
      ) u_dut (
         .clk(clk), .rst(rst), .MC(mc[g]), .addr(addr[g]), .WRdata(wrdata[g]),
         .Mdata(mdata[g]), .ready(ready[g]), .busy(busy[g]), .err(err[g])
      );
   end

   function automatic int wait_of(int k);
      return (k == 2) ? 3 : k;
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // Monitor: collect what is due this cycle for each DUT and compare whenever anything is seen or expected.
   always @(negedge clk) begin
      if (!rst) begin
         for (int g = 0; g < NDUT; g++) begin
            bit            er, ee;
            logic [DW-1:0] em;
            er = 1'b0; ee = 1'b0; em = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
               if (sb[i].dut == g && sb[i].due == cyc) begin
                  if (sb[i].is_rdy) begin
                     er = 1'b1;
                     ee = ee | sb[i].err_exp;
                     em = sb[i].md;
                  end else begin
                     ee = 1'b1;
                  end
                  sb.delete(i);
               end
            end
            if (er || ee || ready[g] || err[g]) begin
               check($sformatf("ready_d%0d", g), 32'(ready[g]), 32'(er));
               check($sformatf("err_d%0d", g), 32'(err[g]), 32'(ee));
               if (er) check($sformatf("mdata_d%0d", g), 32'(mdata[g]), 32'(em));
            end
         end
      end
   end

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic issue(int k, logic [1:0] c, logic [AW-1:0] a, logic [DW-1:0] d);
      int n, bc, t;
      bit inr, wr, rd;
      n   = cyc + 1;
      inr = int'(a) < DEPTH;
      wr  = c[MC_MW];
      rd  = c[MC_MR] && !wr;
      mc[k] = c; addr[k] = a; wrdata[k] = d;
      if (c == 2'b11) sb.push_back('{k, n, 1'b0, 1'b1, '0});
      if (rd) md_model[k] = inr ? mem_model[k][a] : '0;
      if (wr && inr) mem_model[k][a] = d;
      sb.push_back('{k, n + 1 + wait_of(k), 1'b1, !inr, md_model[k]});
      @(negedge clk);
      mc[k] = 2'b00; addr[k] = AW'($urandom); wrdata[k] = DW'($urandom);
      bc = 0; t = 0;
      while (busy[k] && t < 40) begin
         bc++;
         @(negedge clk);
         t++;
      end
      check($sformatf("busy_len_d%0d", k), 32'(bc), 32'(wait_of(k) + 1));
      @(negedge clk);
   endtask

   initial begin
      int n;
      for (int k = 0; k < NDUT; k++) begin
         mc[k] = 2'b00; addr[k] = '0; wrdata[k] = '0; md_model[k] = '0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
         check($sformatf("rst_ready_d%0d", g), 32'(ready[g]), 0);
         check($sformatf("rst_busy_d%0d", g), 32'(busy[g]), 0);
         check($sformatf("rst_err_d%0d", g), 32'(err[g]), 0);
         check($sformatf("rst_mdata_d%0d", g), 32'(mdata[g]), 0);
      end
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < NDUT; k++)
         for (int a = 0; a < DEPTH; a++)
            issue(k, 2'b01, AW'(a), DW'($urandom));

      issue(1, 2'b01, 8'h05, 16'h00F0);
      issue(1, 2'b10, 8'h05, 16'h0000);
      check("wr_rd_05", 32'(mdata[1]), 32'h00F0);
      issue(1, 2'b11, 8'h10, 16'hBEEF);
      check("both_no_read", 32'(mdata[1]), 32'h00F0);
      issue(1, 2'b10, 8'h10, 16'h0000);
      check("both_wrote", 32'(mdata[1]), 32'hBEEF);
      issue(1, 2'b01, 8'hF0, 16'h1234);
      issue(1, 2'b10, 8'hF0, 16'h0000);
      check("oor_read", 32'(mdata[1]), 32'h0000);
      issue(1, 2'b10, 8'd40, 16'h0000);

      // WAIT=0: a second read while busy must be ignored.
      n = cyc + 1;
      mc[0] = 2'b10; addr[0] = 8'h05;
      md_model[0] = mem_model[0][5];
      sb.push_back('{0, n + 1, 1'b1, 1'b0, md_model[0]});
      @(negedge clk);
      check("busy_w0", 32'(busy[0]), 1);
      mc[0] = 2'b10; addr[0] = 8'h06;
      @(negedge clk);
      check("busy_w0_one_cycle", 32'(busy[0]), 0);
      mc[0] = 2'b00;
      repeat (4) @(negedge clk);

      // WAIT=3: reset during wait states aborts the write; rst beats a same-cycle command.
      mc[2] = 2'b01; addr[2] = 8'h07; wrdata[2] = 16'hAAAA;
      @(negedge clk);
      mc[2] = 2'b00;
      check("busy_w3", 32'(busy[2]), 1);
      @(negedge clk);
      rst = 1'b1; mc[2] = 2'b10;
      @(negedge clk);
      rst = 1'b0; mc[2] = 2'b00;
      for (int g = 0; g < NDUT; g++) md_model[g] = '0;
      check("abort_busy", 32'(busy[2]), 0);
      check("abort_ready", 32'(ready[2]), 0);
      check("abort_mdata", 32'(mdata[2]), 0);
      repeat (6) @(negedge clk);
      issue(2, 2'b10, 8'h07, 16'h0000);
      check("abort_no_commit", 32'(mdata[2] == 16'hAAAA && mem_model[2][7] != 16'hAAAA), 0);

      for (int k = 0; k < NDUT; k++) begin
         for (int i = 0; i < 60; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 255)) : AW'($urandom_range(0, 31));
            issue(k, 2'($urandom_range(1, 3)), a, DW'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end

      repeat (5) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 8, address width.
REQ-003 SHALL have parameter DEPTH, default 200, number of implemented words, DEPTH <= 2^ADDR_W.
REQ-004 SHALL have parameter WAIT, default 1, wait states per access, range 0..7.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have port MC, input, 2 bits, memory command: bit0 MW (write), bit1 MR (read).
REQ-008 SHALL have port addr, input, ADDR_W bits, word address, sampled with the command.
REQ-009 SHALL have port WRdata, input, DATA_W bits, write data from the register bank, sampled with MW.
REQ-010 SHALL have port Mdata, output, DATA_W bits, read data to the register bank.
REQ-011 SHALL have port ready, output, 1 bit, one-cycle pulse marking access completion.
REQ-012 SHALL have port busy, output, 1 bit, high while an access is in progress.
REQ-013 SHALL have port err, output, 1 bit, one-cycle pulse flagging an illegal request.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT_ST, ACCESS.
REQ-015 In IDLE, a nonzero MC SHALL be accepted: latch addr, WRdata and op, set busy the next cycle.
REQ-016 After acceptance, the FSM SHALL go to WAIT_ST if WAIT>0, else directly to ACCESS.
REQ-017 WAIT_ST SHALL count WAIT cycles with a 3-bit counter, then go to ACCESS.
REQ-018 ACCESS SHALL last one cycle: commit the write or load Mdata from the array, pulse ready, return to IDLE.
REQ-019 Latency: for a request sampled at edge N, ready SHALL be high in the cycle after edge N+1+WAIT.
REQ-020 busy SHALL be high from the cycle after acceptance through the ACCESS cycle inclusive.
REQ-021 MC SHALL be ignored while busy; no queueing.
REQ-022 If MW and MR are asserted together, MW SHALL win, err SHALL pulse on acceptance, and no read SHALL occur.
REQ-023 If addr >= DEPTH, the FSM SHALL still run the full sequence; a write is dropped, a read returns 0; err SHALL pulse with ready.
REQ-024 Mdata SHALL hold its last read value between reads; writes SHALL NOT change Mdata.
REQ-025 A read of an address written by an earlier completed write SHALL return the new data.
REQ-026 The MC bit meaning SHALL match the register bank: bit0 write, bit1 read, write priority.

Reset
REQ-027 On rst, the FSM SHALL go to IDLE with the wait counter 0; Mdata, ready, busy and err SHALL all be 0.
REQ-028 Reset mid-access SHALL abort it; a pending write SHALL NOT be committed, and no ready pulse SHALL be issued.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 rst SHALL take priority over any MC in the same cycle.

Structure
REQ-031 A shared package SHALL hold: the MC bit indices (MC_MW=0, MC_MR=1), the FSM state enum, and the default DATA_W.
REQ-032 The storage SHALL be a sub-module data_mem_array: single port, synchronous write, registered read, DEPTH x DATA_W.
REQ-033 data_mem_resp SHALL hold only the FSM, counter, request latches and flags.

Verification
REQ-034 With WAIT=1: MW addr=0x05 WRdata=0x00F0, then MR addr=0x05 -> ready at N+2 both times, Mdata=0x00F0.
REQ-035 With WAIT=0: MR issued while busy -> ignored; exactly one ready pulse, busy high for 1 cycle.
REQ-036 MC=2'b11 addr=0x10 WRdata=0xBEEF -> err pulse, write committed, later read of 0x10 = 0xBEEF, Mdata unchanged until that read.
REQ-037 MW addr=0xF0 (>= DEPTH=200) WRdata=0x1234 -> err with ready, no write; MR addr=0xF0 -> Mdata=0x0000.
REQ-038 With WAIT=3: MW addr=0x07 WRdata=0xAAAA, rst in WAIT_ST -> no ready, busy 0 next cycle; MR addr=0x07 returns the prior contents, not 0xAAAA.
